// File: rtl/mux2_arbiter.sv
// Round-robin 2:1 packet arbiter with a registered mux select; a grant is held for a whole packet.
// Latency: a request sampled in IDLE at edge N can transfer its first beat in cycle N+1; one IDLE bubble between packets.
// Backpressure: out_ready passes straight through to the granted requester; the other requester always sees ready=0.
//
// Optional feature: define MUX_ARB_STATS_EN to add per-requester packet counters
// (the CNT_W parameter and the grant_cnt0/grant_cnt1 ports exist only then).
//
// Ports:
//   clk, reset_n              single rising-edge clock, synchronous active-low reset
//   req0_valid/data/last/ready requester 0 beat handshake
//   req1_valid/data/last/ready requester 1 beat handshake
//   out_valid/data/last/ready  shared downstream beat handshake
//   sel                       registered datapath mux select (0 = requester 0)
//   busy                      high while a grant is held
//   grant_cnt0/grant_cnt1     packets completed per requester (MUX_ARB_STATS_EN only)
module mux2_arbiter #(
    parameter int DW = 64
`ifdef MUX_ARB_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req0_valid,
    input  logic [DW-1:0] req0_data,
    input  logic          req0_last,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [DW-1:0] req1_data,
    input  logic          req1_last,
    output logic          req1_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic          sel,
    output logic          busy
`ifdef MUX_ARB_STATS_EN
    , output logic [CNT_W-1:0] grant_cnt0
    , output logic [CNT_W-1:0] grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_sel;
    logic   w_sel_nxt;
    logic   r_last_gnt;
    logic   w_last_gnt_nxt;

    logic   w_xfer0;
    logic   w_xfer1;
    logic   w_done0;
    logic   w_done1;

    // A beat moves only while its requester holds the grant.
    assign w_xfer0 = (r_state == GRANT0) && req0_valid && out_ready;
    assign w_xfer1 = (r_state == GRANT1) && req1_valid && out_ready;
    assign w_done0 = w_xfer0 && req0_last;
    assign w_done1 = w_xfer1 && req1_last;

    // State register. last_gnt resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_sel      <= 1'b0;
            r_last_gnt <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_last_gnt <= w_last_gnt_nxt;
        end
    end

    // Next-state logic. sel is only updated on the IDLE->GRANT transition so
    // the datapath mux never switches in the middle of a packet.
    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_last_gnt_nxt = r_last_gnt;
        case (r_state)
            IDLE: begin
                // Requester 0 wins if it is alone, or on a tie when 1 went last.
                if (req0_valid && (!req1_valid || r_last_gnt)) begin
                    w_state_nxt = GRANT0;
                    w_sel_nxt   = 1'b0;
                end else if (req1_valid) begin
                    w_state_nxt = GRANT1;
                    w_sel_nxt   = 1'b1;
                end
            end
            GRANT0: begin
                if (w_done0) begin
                    w_state_nxt    = IDLE;
                    w_last_gnt_nxt = 1'b0;
                end
            end
            GRANT1: begin
                if (w_done1) begin
                    w_state_nxt    = IDLE;
                    w_last_gnt_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Handshake outputs, decoded from the current state.
    always_comb begin
        out_valid  = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (r_state)
            GRANT0: begin
                out_valid  = req0_valid;
                req0_ready = out_ready;
            end
            GRANT1: begin
                out_valid  = req1_valid;
                req1_ready = out_ready;
            end
            default: begin
                out_valid  = 1'b0;
            end
        endcase
    end

    assign out_data = r_sel ? req1_data : req0_data;
    assign out_last = r_sel ? req1_last : req0_last;
    assign sel      = r_sel;
    assign busy     = (r_state != IDLE);

`ifdef MUX_ARB_STATS_EN
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    // Packet counters bump on the accepted last beat and wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_done0) begin
                r_cnt0 <= r_cnt0 + 1'b1;
            end
            if (w_done1) begin
                r_cnt1 <= r_cnt1 + 1'b1;
            end
        end
    end

    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench for mux2_arbiter: directed packets, expected beats queued at issue time.
// Requester drivers pop a beat after each accepted handshake; a monitor checks every output transfer.
// Downstream backpressure is driven directly by the directed stimulus.
module tb_mux2_arbiter;

    localparam int DW = 64;
`ifdef MUX_ARB_STATS_EN
    localparam int CNT_W = 4;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic          sel;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0_valid;
    logic [DW-1:0] req0_data;
    logic          req0_last;
    logic          req0_ready;
    logic          req1_valid;
    logic [DW-1:0] req1_data;
    logic          req1_last;
    logic          req1_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready;
    logic          sel;
    logic          busy;
`ifdef MUX_ARB_STATS_EN
    logic [CNT_W-1:0] grant_cnt0;
    logic [CNT_W-1:0] grant_cnt1;
`endif

    mux2_arbiter #(
        .DW(DW)
`ifdef MUX_ARB_STATS_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .sel        (sel),
        .busy       (busy)
`ifdef MUX_ARB_STATS_EN
        , .grant_cnt0 (grant_cnt0)
        , .grant_cnt1 (grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    beat_t q0[$];
    beat_t q1[$];
    exp_t  sb[$];
    int    xfer_cyc[$];
    logic  acc0 = 1'b0;
    logic  acc1 = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic add(input int r, input logic [DW-1:0] d, input logic l, input logic expect_it);
        beat_t b;
        exp_t  e;
        b.data = d;
        b.last = l;
        e.sel  = (r == 1);
        e.data = d;
        e.last = l;
        if (r == 0) q0.push_back(b);
        else        q1.push_back(b);
        if (expect_it) sb.push_back(e);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((sb.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(nm, (sb.size() == 0 && q0.size() == 0 && q1.size() == 0), 1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Record which beats the DUT accepted (reset overrides any handshake).
    always @(negedge clk) begin
        acc0 = reset_n && req0_valid && req0_ready;
        acc1 = reset_n && req1_valid && req1_ready;
    end

    // Requester drivers: advance past an accepted beat, present the next one.
    always @(posedge clk) begin
        #1;
        if (acc0 && q0.size() > 0) void'(q0.pop_front());
        if (acc1 && q1.size() > 0) void'(q1.pop_front());
        req0_valid = (q0.size() > 0);
        req0_data  = (q0.size() > 0) ? q0[0].data : '0;
        req0_last  = (q0.size() > 0) ? q0[0].last : 1'b0;
        req1_valid = (q1.size() > 0);
        req1_data  = (q1.size() > 0) ? q1[0].data : '0;
        req1_last  = (q1.size() > 0) ? q1[0].last : 1'b0;
    end

    // Monitor: every downstream transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got sel=%0d data=%0h last=%0d, expected no transfer",
                         sel, out_data, out_last);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("beat", {sel, out_last, out_data}, {e.sel, e.last, e.data});
                xfer_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "timeout");
    end

    initial begin
        int rel;
        int n;
        reset_n    = 1'b0;
        out_ready  = 1'b1;
        req0_valid = 1'b0;
        req0_data  = '0;
        req0_last  = 1'b0;
        req1_valid = 1'b0;
        req1_data  = '0;
        req1_last  = 1'b0;

        // Reset held with both requesters valid; then 1-beat packets alternate 0,1,0,1...
        for (int i = 0; i < 4; i++) begin
            add(0, 64'hA000_0000_0000_0000 + 64'(i), 1'b1, 1'b0);
            add(1, 64'hB000_0000_0000_0000 + 64'(i), 1'b1, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{1'b0, 64'hA000_0000_0000_0000 + 64'(i), 1'b1});
            sb.push_back('{1'b1, 64'hB000_0000_0000_0000 + 64'(i), 1'b1});
        end
        step();
        step();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
`ifdef MUX_ARB_STATS_EN
        chk("rst_cnt0", grant_cnt0, 0);
        chk("rst_cnt1", grant_cnt1, 0);
`endif
        step();
        reset_n = 1'b1;
        rel = cyc;
        drain("rr_drain");
        chk("rr_count", xfer_cyc.size(), 8);
        if (xfer_cyc.size() == 8) begin
            chk("rr_first_latency", xfer_cyc[0] - rel, 1);
            for (int i = 1; i < 8; i++) chk("rr_bubble_gap", xfer_cyc[i] - xfer_cyc[i-1], 2);
        end
`ifdef MUX_ARB_STATS_EN
        chk("rr_cnt0", grant_cnt0, 4);
        chk("rr_cnt1", grant_cnt1, 4);
`endif

        // req1 4-beat packet with stalls; req0 waits for the whole packet.
        step();
        for (int i = 0; i < 4; i++) add(1, 64'hC100_0000_0000_0000 + 64'(i), (i == 3), 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy && sel) && n < 10);
        chk("mp_grant1", {busy, sel}, 2'b11);
        add(0, 64'hC000_0000_0000_0000, 1'b1, 1'b1);
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("mp_sel_hold", sel, 1);
            chk("mp_req0_ready", req0_ready, 0);
            chk("mp_req1_ready_stall", req1_ready, 0);
            chk("mp_busy", busy, 1);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("mp_sel_hold2", sel, 1);
        chk("mp_req0_ready2", req0_ready, 0);
        chk("mp_out_valid_stall", out_valid, 1);
        step();
        out_ready = 1'b1;
        drain("mp_drain");

        // Reset during beat 2 of a 3-beat req0 packet: packet abandoned.
        step();
        add(0, 64'hD000_0000_0000_0000, 1'b0, 1'b1);
        add(0, 64'hD000_0000_0000_0001, 1'b0, 1'b0);
        add(0, 64'hD000_0000_0000_0002, 1'b1, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(req0_valid && req0_ready && req0_data == 64'hD000_0000_0000_0000) && n < 10);
        chk("mr_first_beat", req0_ready, 1);
        step();
        reset_n = 1'b0;
        @(negedge clk);
        q0.delete();
        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("mr_out_valid", out_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_sel", sel, 0);
        chk("mr_req0_ready", req0_ready, 0);
        chk("mr_sb_empty", sb.size(), 0);
        add(1, 64'hE100_0000_0000_0000, 1'b1, 1'b1);
        drain("mr_drain");
`ifdef MUX_ARB_STATS_EN
        chk("mr_cnt0", grant_cnt0, 0);
        chk("mr_cnt1", grant_cnt1, 1);
`endif

        // 17 one-beat packets from req0 only.
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 17; i++) add(0, 64'hF000_0000_0000_0000 + 64'(i * 3), 1'b1, 1'b1);
        drain("wrap_drain");
`ifdef MUX_ARB_STATS_EN
        chk("wrap_cnt0", grant_cnt0, 1);
        chk("wrap_cnt1", grant_cnt1, 0);
`endif

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
